// File: rtl/pip_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// FSM state type and the data-memory wait limit.
package pip_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  localparam logic [3:0] WAIT_MAX = 4'd15;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/pip_fwd_unit.sv
// Per-operand forwarding select: EX/MEM result wins over MEM/WB, x0 never forwards.
module pip_fwd_unit
  import pip_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_memRd,
  input  logic       i_memRdEn,
  input  logic [4:0] i_wbRd,
  input  logic       i_wbRdEn,
  output logic [1:0] o_fwd
);

  always_comb begin
    o_fwd = FWD_RF;
    if (i_memRdEn && (i_memRd != 5'd0) && (i_memRd == i_rs)) begin
      o_fwd = FWD_MEM;
    end else if (i_wbRdEn && (i_wbRd != 5'd0) && (i_wbRd == i_rs)) begin
      o_fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pip_hazard_ctrl.sv
// Pipeline hazard controller: stalls, flushes, operand forwarding and memory-wait FSM.
// Define PIP_HAZARD_FWD_EN to enable forwarding; otherwise RAW hazards stall instead.
module pip_hazard_ctrl
  import pip_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rdEn,
  input  logic        ex_is_load,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rdEn,
  input  logic [4:0]  wb_rd,
  input  logic        wb_rdEn,
  input  logic        br_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic        mem_err,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  state_t      r_state;
  state_t      w_stateNext;
  logic [3:0]  r_waitCnt;
  logic        r_memErr;
  logic [15:0] r_stallCnt;
  logic [15:0] r_flushCnt;
  logic        w_hazard;
  logic        w_waitLast;
  logic [1:0]  w_fwdA;
  logic [1:0]  w_fwdB;

`ifdef PIP_HAZARD_FWD_EN
  pip_fwd_unit u_fwdA (
    .i_rs      (ex_rs1),
    .i_memRd   (mem_rd),
    .i_memRdEn (mem_rdEn),
    .i_wbRd    (wb_rd),
    .i_wbRdEn  (wb_rdEn),
    .o_fwd     (w_fwdA)
  );

  pip_fwd_unit u_fwdB (
    .i_rs      (ex_rs2),
    .i_memRd   (mem_rd),
    .i_memRdEn (mem_rdEn),
    .i_wbRd    (wb_rd),
    .i_wbRdEn  (wb_rdEn),
    .o_fwd     (w_fwdB)
  );

  assign w_hazard = ex_is_load && ex_rdEn && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));
`else
  logic w_hazRs1;
  logic w_hazRs2;
  logic w_unused;

  // Without forwarding any in-flight writer of an ID source must drain; WB is write-through.
  assign w_hazRs1 = (id_rs1 != 5'd0) &&
                    ((ex_rdEn && (ex_rd == id_rs1)) || (mem_rdEn && (mem_rd == id_rs1)));
  assign w_hazRs2 = (id_rs2 != 5'd0) &&
                    ((ex_rdEn && (ex_rd == id_rs2)) || (mem_rdEn && (mem_rd == id_rs2)));
  assign w_hazard = w_hazRs1 || w_hazRs2;
  assign w_fwdA   = FWD_RF;
  assign w_fwdB   = FWD_RF;
  assign w_unused = ^{ex_rs1, ex_rs2, wb_rd, wb_rdEn, ex_is_load};
`endif

  assign w_waitLast = (r_waitCnt == (WAIT_MAX - 4'd1));

  // Priority: memory wait holds everything, then branch flush, then data hazard stall.
  always_comb begin
    w_stateNext = r_state;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    fwd_a       = FWD_RF;
    fwd_b       = FWD_RF;
    if (!rst) begin
      fwd_a = w_fwdA;
      fwd_b = w_fwdB;
      if (r_state == MEM_WAIT) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        if (dmem_ready || w_waitLast) begin
          w_stateNext = RUN;
        end
      end else if (dmem_req && !dmem_ready) begin
        stall_pc    = 1'b1;
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        w_stateNext = MEM_WAIT;
      end else if (br_taken) begin
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end else if (w_hazard) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_waitCnt  <= 4'd0;
      r_memErr   <= 1'b0;
      r_stallCnt <= 16'd0;
      r_flushCnt <= 16'd0;
    end else begin
      r_state <= w_stateNext;
      if ((r_state == RUN) && (w_stateNext == MEM_WAIT)) begin
        r_waitCnt <= 4'd0;
      end else if ((r_state == MEM_WAIT) && !dmem_ready) begin
        r_waitCnt <= r_waitCnt + 4'd1;
        if (w_waitLast) begin
          r_memErr <= 1'b1;
        end
      end
      if (stall_pc && (r_stallCnt != 16'hFFFF)) begin
        r_stallCnt <= r_stallCnt + 16'd1;
      end
      if ((flush_ifid || flush_idex) && (r_flushCnt != 16'hFFFF)) begin
        r_flushCnt <= r_flushCnt + 16'd1;
      end
    end
  end

  assign mem_err   = r_memErr;
  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;

endmodule

// File: tb/tb_pip_hazard_ctrl.sv
// Scoreboard bench for pip_hazard_ctrl: directed scenarios then random traffic
// against a behavioural model; follows PIP_HAZARD_FWD_EN like the design.
module tb_pip_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] idRs1, idRs2, exRs1, exRs2, exRd, memRd, wbRd;
    logic       exRdEn, exIsLoad, memRdEn, wbRdEn, brTaken, dmemReq, dmemReady;
  } stim_t;

  typedef struct {
    logic [5:0]  ctrl;
    logic [1:0]  fa, fb;
    logic [15:0] sc, fc;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  idRs1 = '0, idRs2 = '0, exRs1 = '0, exRs2 = '0, exRd = '0, memRd = '0, wbRd = '0;
  logic        exRdEn = 1'b0, exIsLoad = 1'b0, memRdEn = 1'b0, wbRdEn = 1'b0;
  logic        brTaken = 1'b0, dmemReq = 1'b0, dmemReady = 1'b1;
  logic        stallPc, stallIfid, stallIdex, stallExmem, flushIfid, flushIdex, memErr;
  logic [1:0]  fwdA, fwdB;
  logic [15:0] stallCnt, flushCnt;

  exp_t        sbQ[$];
  int          errors = 0;
  int          checks = 0;

  // Model state, as seen after the most recent clock edge
  bit          mWait = 0;
  int          mWaitLen = 0;
  bit          mErr = 0;
  int          mStalls = 0;
  int          mFlushes = 0;

  always #5 clk = ~clk;

  pip_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(idRs1), .id_rs2(idRs2), .ex_rs1(exRs1), .ex_rs2(exRs2),
    .ex_rd(exRd), .ex_rdEn(exRdEn), .ex_is_load(exIsLoad),
    .mem_rd(memRd), .mem_rdEn(memRdEn), .wb_rd(wbRd), .wb_rdEn(wbRdEn),
    .br_taken(brTaken), .dmem_req(dmemReq), .dmem_ready(dmemReady),
    .stall_pc(stallPc), .stall_ifid(stallIfid), .stall_idex(stallIdex), .stall_exmem(stallExmem),
    .flush_ifid(flushIfid), .flush_idex(flushIdex),
    .fwd_a(fwdA), .fwd_b(fwdB), .mem_err(memErr),
    .stall_cnt(stallCnt), .flush_cnt(flushCnt)
  );

  function automatic stim_t idleStim();
    stim_t s;
    s = '{rst: 1'b0, idRs1: 5'd0, idRs2: 5'd0, exRs1: 5'd0, exRs2: 5'd0, exRd: 5'd0,
          memRd: 5'd0, wbRd: 5'd0, exRdEn: 1'b0, exIsLoad: 1'b0, memRdEn: 1'b0,
          wbRdEn: 1'b0, brTaken: 1'b0, dmemReq: 1'b0, dmemReady: 1'b1};
    return s;
  endfunction

  function automatic stim_t randStim();
    stim_t s;
    s.rst       = ($urandom_range(0, 63) == 0);
    s.idRs1     = 5'($urandom_range(0, 7));
    s.idRs2     = 5'($urandom_range(0, 7));
    s.exRs1     = 5'($urandom_range(0, 7));
    s.exRs2     = 5'($urandom_range(0, 7));
    s.exRd      = 5'($urandom_range(0, 7));
    s.memRd     = 5'($urandom_range(0, 7));
    s.wbRd      = 5'($urandom_range(0, 7));
    s.exRdEn    = 1'($urandom_range(0, 1));
    s.exIsLoad  = 1'($urandom_range(0, 1));
    s.memRdEn   = 1'($urandom_range(0, 1));
    s.wbRdEn    = 1'($urandom_range(0, 1));
    s.brTaken   = ($urandom_range(0, 4) == 0);
    s.dmemReq   = ($urandom_range(0, 5) == 0);
    s.dmemReady = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  // Which pipeline register holds the newest value of rs (0 = none / x0)
  function automatic logic [1:0] fwdSel(logic [4:0] rs, stim_t s);
`ifdef PIP_HAZARD_FWD_EN
    if (rs != 0 && s.memRdEn && s.memRd == rs) return 2'b01;
    if (rs != 0 && s.wbRdEn && s.wbRd == rs) return 2'b10;
`endif
    return 2'b00;
  endfunction

  function automatic bit srcBlocked(logic [4:0] rs, stim_t s);
    if (rs == 0) return 0;
`ifdef PIP_HAZARD_FWD_EN
    return s.exIsLoad && s.exRdEn && s.exRd == rs;
`else
    return (s.exRdEn && s.exRd == rs) || (s.memRdEn && s.memRd == rs);
`endif
  endfunction

  task automatic applyStimulus(input stim_t s);
    exp_t e;
    bit   hold, brFlush, hazStall;
    @(posedge clk);
    #1;
    rst = s.rst; idRs1 = s.idRs1; idRs2 = s.idRs2; exRs1 = s.exRs1; exRs2 = s.exRs2;
    exRd = s.exRd; memRd = s.memRd; wbRd = s.wbRd; exRdEn = s.exRdEn; exIsLoad = s.exIsLoad;
    memRdEn = s.memRdEn; wbRdEn = s.wbRdEn; brTaken = s.brTaken;
    dmemReq = s.dmemReq; dmemReady = s.dmemReady;

    hold     = !s.rst && (mWait || (s.dmemReq && !s.dmemReady));
    brFlush  = !s.rst && !hold && s.brTaken;
    hazStall = !s.rst && !hold && !s.brTaken &&
               (srcBlocked(s.idRs1, s) || srcBlocked(s.idRs2, s));
    e.ctrl = {hold || hazStall, hold || hazStall, hold, hold, brFlush, brFlush || hazStall};
    e.fa   = s.rst ? 2'b00 : fwdSel(s.exRs1, s);
    e.fb   = s.rst ? 2'b00 : fwdSel(s.exRs2, s);
    e.sc   = 16'(mStalls);
    e.fc   = 16'(mFlushes);
    e.err  = mErr;
    sbQ.push_back(e);

    if (s.rst) begin
      mWait = 0; mWaitLen = 0; mErr = 0; mStalls = 0; mFlushes = 0;
    end else begin
      if (e.ctrl[5] && mStalls < 65535) mStalls++;
      if ((e.ctrl[1] || e.ctrl[0]) && mFlushes < 65535) mFlushes++;
      if (!mWait) begin
        if (s.dmemReq && !s.dmemReady) begin
          mWait = 1;
          mWaitLen = 0;
        end
      end else if (s.dmemReady) begin
        mWait = 0;
      end else begin
        mWaitLen++;
        if (mWaitLen == 15) begin
          mErr = 1;
          mWait = 0;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    chk("ctrl{spc,sif,sidx,sexm,fif,fidx}",
        16'({stallPc, stallIfid, stallIdex, stallExmem, flushIfid, flushIdex}), 16'(e.ctrl));
    chk("fwd_a", 16'(fwdA), 16'(e.fa));
    chk("fwd_b", 16'(fwdB), 16'(e.fb));
    chk("stall_cnt", stallCnt, e.sc);
    chk("flush_cnt", flushCnt, e.fc);
    chk("mem_err", 16'(memErr), 16'(e.err));
  endtask

  always @(negedge clk) begin
    if (sbQ.size() > 0) checkOutput(sbQ.pop_front());
  end

  initial begin
    stim_t s;
    repeat (2) @(posedge clk);

    // Forwarding priority and x0
    s = idleStim(); s.exRs1 = 5; s.memRd = 5; s.memRdEn = 1; s.wbRd = 5; s.wbRdEn = 1;
    s.exRs2 = 9;
    applyStimulus(s);
    s.memRdEn = 0; s.wbRd = 9; applyStimulus(s);
    s.memRdEn = 1; s.exRs1 = 0; s.exRs2 = 5; applyStimulus(s);
    applyStimulus(idleStim());

    // Load-use, then the same hazard alongside a taken branch
    s = idleStim(); s.exIsLoad = 1; s.exRdEn = 1; s.exRd = 7; s.idRs2 = 7;
    applyStimulus(s);
    applyStimulus(idleStim());
    s.brTaken = 1; applyStimulus(s);
    applyStimulus(idleStim());

    // Short memory wait
    s = idleStim(); s.dmemReq = 1; s.dmemReady = 0;
    repeat (3) applyStimulus(s);
    s.dmemReady = 1; applyStimulus(s);
    repeat (2) applyStimulus(idleStim());

    // Memory timeout and sticky error
    s = idleStim(); s.dmemReq = 1; s.dmemReady = 0;
    repeat (16) applyStimulus(s);
    repeat (3) applyStimulus(idleStim());

    // Reset while waiting
    s = idleStim(); s.dmemReq = 1; s.dmemReady = 0;
    repeat (4) applyStimulus(s);
    s.rst = 1; applyStimulus(s);
    repeat (2) applyStimulus(idleStim());

    // RAW on ex_rd without a load
    s = idleStim(); s.exRd = 3; s.exRdEn = 1; s.idRs1 = 3; s.exRs1 = 3;
    applyStimulus(s);
    applyStimulus(idleStim());

    for (int i = 0; i < 600; i++) applyStimulus(randStim());

    @(posedge clk);
    #1;
    checks++;
    if (sbQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", sbQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
